// File: rtl/period_ctrl_pkg.sv
// Shared definitions for the period controller: FSM state encoding.
package period_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    PAUSE = ST_PAUSE
  } state_t;

endpackage

// File: rtl/period_ctrl_prescaler.sv
// Down-counting prescaler: reloads max_val after terminal count, freezes when en is low.
module prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [PRE_W-1:0] max_val,
  output logic             tc
);

  logic [PRE_W-1:0] cnt_r;

  assign tc = (cnt_r == '0);

  // Counter register: load has priority, then count down / reload on terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= max_val;
    end else if (en) begin
      cnt_r <= tc ? max_val : (cnt_r - PRE_W'(1));
    end
  end

endmodule

// File: rtl/period_ctrl.sv
// Start/stop/pause controller that paces a clear/increment counter and counts its wrap periods.
module period_ctrl
  import period_ctrl_pkg::*;
#(
  parameter int PRE_W = 8,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode_oneshot,
  input  logic [PRE_W-1:0] prescale,
  input  logic [REP_W-1:0] reps,
  input  logic             cnt_eq,
  output logic             inc,
  output logic             clr,
  output logic             tick,
  output logic             done,
  output logic             busy,
  output logic [REP_W-1:0] rep_cnt
);

  state_t           state_r, state_s;
  logic [PRE_W-1:0] prescale_q_r;
  logic [REP_W-1:0] reps_q_r;
  logic             oneshot_q_r;
  logic [REP_W-1:0] rep_cnt_r;
  logic             tick_r;
  logic             done_r;

  logic             tc_s;
  logic             start_ok_s;
  logic             strobe_s;
  logic             wrap_s;
  logic             last_s;
  logic [REP_W-1:0] rep_next_s;
  logic [REP_W-1:0] reps_eff_s;
  logic [PRE_W-1:0] pre_max_s;
  logic             inc_s;
  logic             clr_s;

  // While idle the prescaler must load the live input, since the shadow copy is written on the same edge.
  assign pre_max_s  = (state_r == IDLE) ? prescale : prescale_q_r;
  assign start_ok_s = (state_r == IDLE) && start && !stop;
  assign strobe_s   = (state_r == RUN) && tc_s;
  assign wrap_s     = strobe_s && cnt_eq;
  assign rep_next_s = rep_cnt_r + REP_W'(1);
  assign reps_eff_s = (reps_q_r == '0) ? REP_W'(1) : reps_q_r;
  assign last_s     = oneshot_q_r && (rep_next_s == reps_eff_s);

  prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state_r == RUN),
    .load    (start_ok_s),
    .max_val (pre_max_s),
    .tc      (tc_s)
  );

  // Next-state and counter-strobe decode; stop outranks completion, which outranks pause.
  always_comb begin
    state_s = state_r;
    inc_s   = 1'b0;
    clr_s   = 1'b0;
    case (state_r)
      IDLE: begin
        clr_s = 1'b1;
        if (start_ok_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        inc_s = strobe_s && !cnt_eq;
        clr_s = wrap_s;
        if (stop) begin
          state_s = IDLE;
        end else if (wrap_s && last_s) begin
          state_s = IDLE;
        end else if (pause) begin
          state_s = PAUSE;
        end else begin
          state_s = RUN;
        end
      end
      PAUSE: begin
        if (stop) begin
          state_s = IDLE;
        end else if (!pause) begin
          state_s = RUN;
        end else begin
          state_s = PAUSE;
        end
      end
      default: begin
        state_s = IDLE;
        clr_s   = 1'b1;
      end
    endcase
  end

  // State, shadow and period bookkeeping; a stop on a wrap edge suppresses that wrap's effects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      prescale_q_r <= '0;
      reps_q_r     <= '0;
      oneshot_q_r  <= 1'b0;
      rep_cnt_r    <= '0;
      tick_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r <= state_s;
      tick_r  <= 1'b0;
      done_r  <= 1'b0;
      if (start_ok_s) begin
        prescale_q_r <= prescale;
        reps_q_r     <= reps;
        oneshot_q_r  <= mode_oneshot;
        rep_cnt_r    <= '0;
      end else if (wrap_s && !stop) begin
        rep_cnt_r <= rep_next_s;
        tick_r    <= 1'b1;
        done_r    <= last_s;
      end
    end
  end

  assign inc     = inc_s;
  assign clr     = clr_s;
  assign tick    = tick_r;
  assign done    = done_r;
  assign busy    = (state_r != IDLE);
  assign rep_cnt = rep_cnt_r;

endmodule

// File: tb/tb_period_ctrl.sv
// Directed bench for period_ctrl driving a small clear/increment counter model.
module tb_period_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start, stop, pause, mode_oneshot;
  logic [7:0] prescale;
  logic [1:0] reps;
  logic       cnt_eq;
  logic       inc, clr, tick, done, busy;
  logic [1:0] rep_cnt;

  logic [3:0] cnt_m;
  logic [3:0] max_val;

  int tests;
  int fails;
  int tick_seen;

  period_ctrl #(.PRE_W(8), .REP_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .pause        (pause),
    .mode_oneshot (mode_oneshot),
    .prescale     (prescale),
    .reps         (reps),
    .cnt_eq       (cnt_eq),
    .inc          (inc),
    .clr          (clr),
    .tick         (tick),
    .done         (done),
    .busy         (busy),
    .rep_cnt      (rep_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External counter being paced by the controller
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt_m <= 4'd0;
    else if (clr) cnt_m <= 4'd0;
    else if (inc) cnt_m <= cnt_m + 4'd1;
  end
  assign cnt_eq = (cnt_m == max_val);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    mode_oneshot = 1'b0; prescale = 8'd0; reps = 2'd0; max_val = 4'd3;
    #3;
    check("rst_clr", 32'(clr), 32'd1);
    check("rst_inc", 32'(inc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rep", 32'(rep_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Free-running, prescale 0, max 3: 4-cycle period, rep_cnt rolls 3 -> 0
    go();
    for (int k = 1; k <= 17; k++) begin
      check("fr_inc", 32'(inc), 32'((k % 4) != 0));
      check("fr_clr", 32'(clr), 32'((k % 4) == 0));
      check("fr_tick", 32'(tick), 32'((k > 1) && ((k - 1) % 4 == 0)));
      check("fr_rep", 32'(rep_cnt), 32'(((k - 1) / 4) % 4));
      step();
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_clr", 32'(clr), 32'd1);
    check("mid_rst_inc", 32'(inc), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rep", 32'(rep_cnt), 32'd0);
    check("mid_rst_tick", 32'(tick), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // One-shot, prescale 2, max 1, reps 2: done 12 cycles after start
    max_val = 4'd1; prescale = 8'd2; mode_oneshot = 1'b1; reps = 2'd2;
    go();
    mode_oneshot = 1'b0; prescale = 8'd0;
    tick_seen = 0;
    for (int k = 1; k <= 13; k++) begin
      check("os_inc", 32'(inc), 32'((k == 3) || (k == 9)));
      check("os_clr", 32'(clr), 32'((k == 6) || (k == 12) || (k == 13)));
      check("os_tick", 32'(tick), 32'((k == 7) || (k == 13)));
      check("os_done", 32'(done), 32'(k == 13));
      check("os_busy", 32'(busy), 32'(k <= 12));
      if (tick) tick_seen++;
      step();
    end
    check("os_ticks", 32'(tick_seen), 32'd2);
    check("os_rep", 32'(rep_cnt), 32'd2);

    // One-shot with reps 0 behaves as reps 1
    max_val = 4'd1; prescale = 8'd0; mode_oneshot = 1'b1; reps = 2'd0;
    go();
    for (int k = 1; k <= 3; k++) begin
      check("r0_inc", 32'(inc), 32'(k == 1));
      check("r0_clr", 32'(clr), 32'(k >= 2));
      check("r0_tick", 32'(tick), 32'(k == 3));
      check("r0_done", 32'(done), 32'(k == 3));
      check("r0_busy", 32'(busy), 32'(k <= 2));
      step();
    end
    check("r0_rep", 32'(rep_cnt), 32'd1);

    // Pause for 5 cycles mid-period, plus an ignored start and input change mid-run
    max_val = 4'd3; prescale = 8'd1; mode_oneshot = 1'b0; reps = 2'd0;
    go();
    for (int k = 1; k <= 14; k++) begin
      if (k == 3)  pause = 1'b1;
      if (k == 8)  pause = 1'b0;
      if (k == 10) begin start = 1'b1; prescale = 8'd7; end
      if (k == 11) start = 1'b0;
      check("pz_inc", 32'(inc), 32'((k == 2) || (k == 9) || (k == 11)));
      check("pz_clr", 32'(clr), 32'(k == 13));
      check("pz_tick", 32'(tick), 32'(k == 14));
      check("pz_busy", 32'(busy), 32'd1);
      if (k >= 4 && k <= 8) check("pz_hold", 32'(cnt_m), 32'd1);
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("pz_stop_busy", 32'(busy), 32'd0);
    check("pz_stop_clr", 32'(clr), 32'd1);
    check("pz_stop_rep", 32'(rep_cnt), 32'd1);

    // Stop on the same edge as a wrap: no tick, no done, rep_cnt held
    max_val = 4'd1; prescale = 8'd0; mode_oneshot = 1'b0;
    go();
    for (int k = 1; k <= 4; k++) begin
      check("st_inc", 32'(inc), 32'((k == 1) || (k == 3)));
      check("st_clr", 32'(clr), 32'((k == 2) || (k == 4)));
      check("st_tick", 32'(tick), 32'(k == 3));
      if (k == 4) stop = 1'b1;
      step();
    end
    stop = 1'b0;
    check("st_tick_after", 32'(tick), 32'd0);
    check("st_done_after", 32'(done), 32'd0);
    check("st_busy_after", 32'(busy), 32'd0);
    check("st_clr_after", 32'(clr), 32'd1);
    check("st_rep_after", 32'(rep_cnt), 32'd1);

    // start together with stop in IDLE is not honoured
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("ss_busy", 32'(busy), 32'd0);
    check("ss_rep", 32'(rep_cnt), 32'd1);
    step();
    check("ss_busy2", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/period_ctrl.md
# period_ctrl

Control stage that drives the team's clear/increment counter (`clr`, `inc` in; `cnt`, `eq` out). Runs a start/stop/pause FSM with a programmable prescaler that issues `inc` strobes, consumes the counter's `eq` flag to detect wrap, and issues `clr` to restart the count. Counts completed periods, pulses `tick` per period, and in one-shot mode finishes after a programmed number of periods.

## Interface
- `PRE_W`, default 8: prescaler width.
- `REP_W`, default 8: repetition counter width.

- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin run; honoured only in IDLE.
- `stop` in 1: abort run; returns to IDLE.
- `pause` in 1: level; freezes the run while high.
- `mode_oneshot` in 1: 1 = stop after `reps` periods; 0 = free-running.
- `prescale` in PRE_W: clocks per increment minus one.
- `reps` in REP_W: period count for one-shot; 0 is treated as 1.
- `cnt_eq` in 1: counter `eq` (count == max_val).
- `inc` out 1: increment strobe to counter; combinational from registers.
- `clr` out 1: clear to counter; combinational from registers.
- `tick` out 1: registered one-cycle pulse per completed period.
- `done` out 1: registered one-cycle pulse at one-shot completion.
- `busy` out 1: state != IDLE.
- `rep_cnt` out REP_W: completed periods in the current run.

## Operation
- States: IDLE, RUN, PAUSE.
- IDLE: `clr`=1, `inc`=0. On `start` (and not `stop`): latch `prescale`, `reps`, `mode_oneshot` into shadow regs; `pre`<=0; `rep_cnt`<=0; go RUN.
- RUN: `pre` counts 0..prescale_q, then returns to 0. Strobe cycle = RUN and `pre`==prescale_q.
  - Strobe with `cnt_eq`=0: `inc`=1, `clr`=0.
  - Strobe with `cnt_eq`=1: wrap. `inc`=0, `clr`=1, `rep_cnt`<=`rep_cnt`+1 (mod 2^REP_W), `tick`<=1.
  - Non-strobe cycle: `inc`=0, `clr`=0.
- One-shot: on a wrap where `rep_cnt`+1 == max(reps_q,1), set `done`<=1 and go IDLE.
- Free-running: wraps continue indefinitely; `rep_cnt` rolls over 2^REP_W-1 -> 0.
- PAUSE: `inc`=0, `clr`=0, `pre` frozen. Go RUN when `pause`=0.
- Transition priority from RUN/PAUSE: `stop` > one-shot completion > `pause`. `stop` gives IDLE, no `tick`, no `done`; `rep_cnt` holds its value until the next `start`.
- A wrap in the same cycle that `pause` rises still takes effect (`clr`, `tick`, `rep_cnt`), then the FSM enters PAUSE.
- `start` outside IDLE is ignored. `start` and `stop` together in IDLE: remain IDLE.
- Shadow regs are frozen during a run; input changes apply at the next `start`.

## Timing
- Reset values: state IDLE, `pre`=0, `rep_cnt`=0, `tick`=0, `done`=0, `busy`=0. `clr`=1 and `inc`=0 during reset, which holds the counter cleared.
- `start` sampled at edge E. RUN begins after E. The first strobe occurs prescale_q+1 cycles after E.
- Period = (max_val+1)×(prescale_q+1) cycles. The counter holds max_val for one prescale interval, then clears.
- `tick` and `done` are asserted in the cycle after the wrap cycle. `busy` falls in that same cycle after one-shot completion.
- `pause` and `stop` take effect at the next edge. Output changes are visible one cycle after the input is sampled.

## Structure
- Package `period_ctrl_pkg`: FSM state encoding localparams (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2).
- Sub-module `prescaler`: PRE_W down-counter with `en`, `load`, and terminal-count output.
- Top level contains the FSM, shadow regs, rep counter, and output decode.

## Test plan
- prescale=0, max_val=3, free-running, start: `inc` high 3 cycles, `clr` 1 cycle, repeating every 4 cycles; `tick` every 4 cycles; `rep_cnt` 1,2,3…
- prescale=2, max_val=1, one-shot, reps=2: `done` pulses 12 cycles after `start`; `busy` drops; exactly 2 `tick` pulses.
- reps=0, one-shot: behaves as reps=1 with a single `tick` and a `done`.
- `pause` held for 5 cycles mid-period: no `inc`; counter value and `pre` preserved; the period is lengthened by exactly 5 cycles.
- `stop` on the same edge as a wrap strobe: IDLE entered, `clr`=1, no `tick`, no `done`. `start` with `stop` in IDLE: stays IDLE.
- `rst_n` asserted mid-run, free-running with REP_W=2: outputs return to reset values immediately. A separate run checks `rep_cnt` rollover 3 -> 0.
